// File: rtl/tdp_ram_gen_pkg.sv
// Shared types and constants for the tdp_ram_gen true dual-port RAM.
// Holds the sweep FSM state enum, the address-width helper and parameter limits.
package tdp_ram_gen_pkg;

    typedef enum logic {
        ST_CLR = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    localparam int DATA_WIDTH_MIN = 8;
    localparam int DATA_WIDTH_MAX = 128;
    localparam int DEPTH_MIN      = 16;
    localparam int DEPTH_MAX      = 32768;

    // Smallest n with 2**n >= value.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tdp_ram_gen_core.sv
// Byte-enabled true dual-port storage array with registered, read-first reads.
// When both ports write one address, port A owns its enabled bytes; B fills the rest.
module tdp_ram_gen_core
    import tdp_ram_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    localparam int AW        = clog2(DEPTH),
    localparam int NB        = DATA_WIDTH / 8
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  we_a,
    input  logic                  re_a,
    input  logic [NB-1:0]         be_a,
    input  logic [AW-1:0]         addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic                  we_b,
    input  logic                  re_b,
    input  logic [NB-1:0]         be_b,
    input  logic [AW-1:0]         addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_a_reg;
    logic [DATA_WIDTH-1:0] rdata_b_reg;

    // Port A is assigned last so it wins the overlapping bytes of a shared address.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NB; i++) begin
            if (we_b && be_b[i]) begin
                mem[addr_b][i*8 +: 8] <= wdata_b[i*8 +: 8];
            end
            if (we_a && be_a[i]) begin
                mem[addr_a][i*8 +: 8] <= wdata_a[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rdata_a_reg <= '0;
        end else if (re_a) begin
            rdata_a_reg <= mem[addr_a];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rdata_b_reg <= '0;
        end else if (re_b) begin
            rdata_b_reg <= mem[addr_b];
        end
    end

    assign rdata_a = rdata_a_reg;
    assign rdata_b = rdata_b_reg;

endmodule

// File: rtl/tdp_ram_gen.sv
// True dual-port RAM with a power-up/on-demand clear sweep and collision flag.
// Define TDP_RAM_GEN_OUTREG_EN to add one output register stage (read latency 2).
module tdp_ram_gen
    import tdp_ram_gen_pkg::*;
#(
    parameter int                        DATA_WIDTH = 32,
    parameter int                        DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0]     INIT_VALUE = '0,
    localparam int                       AW         = clog2(DEPTH),
    localparam int                       NB         = DATA_WIDTH / 8
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  CLEAR,
    output logic                  BUSY,
    input  logic                  WEN_A,
    input  logic                  WEN_B,
    input  logic                  REN_A,
    input  logic                  REN_B,
    input  logic [NB-1:0]         BE_A,
    input  logic [NB-1:0]         BE_B,
    input  logic [AW-1:0]         ADDR_A,
    input  logic [AW-1:0]         ADDR_B,
    input  logic [DATA_WIDTH-1:0] WDATA_A,
    input  logic [DATA_WIDTH-1:0] WDATA_B,
    output logic [DATA_WIDTH-1:0] RDATA_A,
    output logic [DATA_WIDTH-1:0] RDATA_B,
    output logic                  RVALID_A,
    output logic                  RVALID_B,
    output logic                  COLLISION
);

    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX || (DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("tdp_ram_gen: DATA_WIDTH must be a multiple of 8 in 8..128");
    end
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("tdp_ram_gen: DEPTH must be a power of two in 16..32768");
    end

    state_t          state_reg, state_next;
    logic [AW-1:0]   cnt_reg, cnt_next;
    logic            run;
    logic            rvalid_a_reg, rvalid_b_reg, collision_reg;
    logic            collision_next;

    logic                  core_we_a, core_re_a, core_we_b, core_re_b;
    logic [NB-1:0]         core_be_a;
    logic [AW-1:0]         core_addr_a;
    logic [DATA_WIDTH-1:0] core_wdata_a;
    logic [DATA_WIDTH-1:0] rdata_a_core, rdata_b_core;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= ST_CLR;
            cnt_reg       <= '0;
            rvalid_a_reg  <= 1'b0;
            rvalid_b_reg  <= 1'b0;
            collision_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rvalid_a_reg  <= core_re_a;
            rvalid_b_reg  <= core_re_b;
            collision_reg <= collision_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_CLR: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == AW'(DEPTH - 1)) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            ST_RUN: begin
                if (CLEAR) begin
                    state_next = ST_CLR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_CLR;
                cnt_next   = '0;
            end
        endcase
    end

    // During the sweep port A is borrowed for the INIT_VALUE writes; user traffic is dropped.
    always_comb begin
        run          = (state_reg == ST_RUN);
        BUSY         = !run;
        core_we_a    = WEN_A;
        core_be_a    = BE_A;
        core_addr_a  = ADDR_A;
        core_wdata_a = WDATA_A;
        if (!run) begin
            core_we_a    = 1'b1;
            core_be_a    = '1;
            core_addr_a  = cnt_reg;
            core_wdata_a = INIT_VALUE;
        end
        core_re_a      = run && REN_A;
        core_we_b      = run && WEN_B;
        core_re_b      = run && REN_B;
        collision_next = run && (REN_A || WEN_A) && (REN_B || WEN_B)
                         && (WEN_A || WEN_B) && (ADDR_A == ADDR_B);
    end

    tdp_ram_gen_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_core (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .we_a    (core_we_a),
        .re_a    (core_re_a),
        .be_a    (core_be_a),
        .addr_a  (core_addr_a),
        .wdata_a (core_wdata_a),
        .rdata_a (rdata_a_core),
        .we_b    (core_we_b),
        .re_b    (core_re_b),
        .be_b    (BE_B),
        .addr_b  (ADDR_B),
        .wdata_b (WDATA_B),
        .rdata_b (rdata_b_core)
    );

`ifdef TDP_RAM_GEN_OUTREG_EN
    logic [DATA_WIDTH-1:0] rdata_a_q, rdata_b_q;
    logic                  rvalid_a_q, rvalid_b_q, collision_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            rdata_a_q   <= rdata_a_core;
            rdata_b_q   <= rdata_b_core;
            rvalid_a_q  <= rvalid_a_reg;
            rvalid_b_q  <= rvalid_b_reg;
            collision_q <= collision_reg;
        end
    end

    assign RDATA_A   = rdata_a_q;
    assign RDATA_B   = rdata_b_q;
    assign RVALID_A  = rvalid_a_q;
    assign RVALID_B  = rvalid_b_q;
    assign COLLISION = collision_q;
`else
    assign RDATA_A   = rdata_a_core;
    assign RDATA_B   = rdata_b_core;
    assign RVALID_A  = rvalid_a_reg;
    assign RVALID_B  = rvalid_b_reg;
    assign COLLISION = collision_reg;
`endif

endmodule

// File: tb/tb_tdp_ram_gen.sv
// Directed self-checking bench for tdp_ram_gen (32-bit x 1024, INIT_VALUE A5A5A5A5).
module tb_tdp_ram_gen;

`ifdef TDP_RAM_GEN_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        CLEAR;
    logic        BUSY;
    logic        WEN_A, WEN_B, REN_A, REN_B;
    logic [3:0]  BE_A, BE_B;
    logic [9:0]  ADDR_A, ADDR_B;
    logic [31:0] WDATA_A, WDATA_B;
    logic [31:0] RDATA_A, RDATA_B;
    logic        RVALID_A, RVALID_B;
    logic        COLLISION;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 CLK = ~CLK;

    tdp_ram_gen #(
        .DATA_WIDTH (32),
        .DEPTH      (1024),
        .INIT_VALUE (32'hA5A5A5A5)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .CLEAR     (CLEAR),
        .BUSY      (BUSY),
        .WEN_A     (WEN_A),
        .WEN_B     (WEN_B),
        .REN_A     (REN_A),
        .REN_B     (REN_B),
        .BE_A      (BE_A),
        .BE_B      (BE_B),
        .ADDR_A    (ADDR_A),
        .ADDR_B    (ADDR_B),
        .WDATA_A   (WDATA_A),
        .WDATA_B   (WDATA_B),
        .RDATA_A   (RDATA_A),
        .RDATA_B   (RDATA_B),
        .RVALID_A  (RVALID_A),
        .RVALID_B  (RVALID_B),
        .COLLISION (COLLISION)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
        $display("check %-16s observed %h expected %h", tag, observed, expected);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        WEN_A = 1'b0; WEN_B = 1'b0; REN_A = 1'b0; REN_B = 1'b0; CLEAR = 1'b0;
    endtask

    // Launch the currently driven operation, then wait until its results are visible.
    task automatic op_done;
        tick;
        idle;
        repeat (LAT - 1) tick;
    endtask

    task automatic set_a(input logic wen, input logic ren, input logic [9:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        WEN_A = wen; REN_A = ren; ADDR_A = addr; WDATA_A = wdata; BE_A = be;
    endtask

    task automatic set_b(input logic wen, input logic ren, input logic [9:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        WEN_B = wen; REN_B = ren; ADDR_B = addr; WDATA_B = wdata; BE_B = be;
    endtask

    initial begin
        RESET_N = 1'b0;
        idle;
        set_a(0, 0, '0, '0, '0);
        set_b(0, 0, '0, '0, '0);
        repeat (3) tick;
        check("rst_busy", {31'b0, BUSY}, 32'd1);
        check("rst_rvalid_a", {31'b0, RVALID_A}, 32'd0);
        check("rst_rdata_b", RDATA_B, 32'd0);
        check("rst_collision", {31'b0, COLLISION}, 32'd0);

        RESET_N = 1'b1;
        n = 0;
        while (BUSY === 1'b1 && n < 3000) begin
            tick;
            n++;
        end
        check("sweep_len", n, 32'd1024);

        set_a(0, 1, 10'd1023, '0, '0);
        op_done;
        check("rd1023_data", RDATA_A, 32'hA5A5A5A5);
        check("rd1023_valid", {31'b0, RVALID_A}, 32'd1);
        tick;
        check("hold_valid_a", {31'b0, RVALID_A}, 32'd0);
        check("hold_data_a", RDATA_A, 32'hA5A5A5A5);

        set_a(1, 0, 10'd5, 32'h11223344, 4'b0101);
        op_done;
        check("wr_only_coll", {31'b0, COLLISION}, 32'd0);
        set_b(0, 1, 10'd5, '0, '0);
        op_done;
        check("be_merge", RDATA_B, 32'hA522A544);
        check("be_merge_valid", {31'b0, RVALID_B}, 32'd1);
        tick;
        check("hold_valid_b", {31'b0, RVALID_B}, 32'd0);
        check("hold_data_b", RDATA_B, 32'hA522A544);

        set_a(1, 0, 10'd5, 32'hFFFFFFFF, 4'b0000);
        op_done;
        set_a(0, 1, 10'd5, '0, '0);
        op_done;
        check("be_zero_noop", RDATA_A, 32'hA522A544);

        set_a(1, 0, 10'd9, 32'hDEADBEEF, 4'b1111);
        set_b(0, 1, 10'd9, '0, '0);
        op_done;
        check("wa_rb_old", RDATA_B, 32'hA5A5A5A5);
        check("wa_rb_coll", {31'b0, COLLISION}, 32'd1);
        tick;
        check("coll_one_cycle", {31'b0, COLLISION}, 32'd0);
        set_b(0, 1, 10'd9, '0, '0);
        op_done;
        check("rd9_new", RDATA_B, 32'hDEADBEEF);

        set_a(1, 1, 10'd9, 32'h12345678, 4'b1111);
        op_done;
        check("read_first", RDATA_A, 32'hDEADBEEF);
        check("same_port_coll", {31'b0, COLLISION}, 32'd0);

        set_a(0, 1, 10'd9, '0, '0);
        set_b(0, 1, 10'd9, '0, '0);
        op_done;
        check("rr_data_a", RDATA_A, 32'h12345678);
        check("rr_data_b", RDATA_B, 32'h12345678);
        check("rr_no_coll", {31'b0, COLLISION}, 32'd0);

        set_a(1, 0, 10'd3, 32'h000000FF, 4'b0001);
        set_b(1, 0, 10'd3, 32'hFFFFFF00, 4'b1111);
        op_done;
        check("ww_coll", {31'b0, COLLISION}, 32'd1);
        set_a(0, 1, 10'd3, '0, '0);
        op_done;
        check("ww_merge3", RDATA_A, 32'hFFFFFFFF);

        set_a(1, 0, 10'd4, 32'h000000AA, 4'b0011);
        set_b(1, 0, 10'd4, 32'h11223344, 4'b0110);
        op_done;
        set_b(0, 1, 10'd4, '0, '0);
        op_done;
        check("ww_a_priority", RDATA_B, 32'hA52200AA);

        set_a(1, 0, 10'd7, 32'h77777777, 4'b1111);
        CLEAR = 1'b1;
        tick;
        idle;
        check("clear_busy", {31'b0, BUSY}, 32'd1);
        repeat (500) tick;
        RESET_N = 1'b0;
        #1;
        check("midrst_busy", {31'b0, BUSY}, 32'd1);
        check("midrst_rdata_a", RDATA_A, 32'd0);
        tick;
        RESET_N = 1'b1;

        n = 0;
        while (BUSY === 1'b1 && n < 3000) begin
            if (n == 20) begin
                set_b(1, 0, 10'd10, 32'h12345678, 4'b1111);
                set_a(0, 1, 10'd10, '0, '0);
                CLEAR = 1'b1;
            end
            tick;
            n++;
            if (n == 21) begin
                idle;
                check("clr_no_rvalid", {31'b0, RVALID_A}, 32'd0);
            end
        end
        check("resweep_len", n, 32'd1024);

        set_a(0, 1, 10'd10, '0, '0);
        op_done;
        check("clr_wr_ignored", RDATA_A, 32'hA5A5A5A5);
        set_b(0, 1, 10'd9, '0, '0);
        op_done;
        check("cleared_9", RDATA_B, 32'hA5A5A5A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
